// File: rtl/multdiv_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// multdiv_sequencer_pkg
//   Shared definitions for the multdiv sequencer slice:
//     - state_t        : sequencer FSM states (2-bit encoding)
//     - ALU_OP_MUL/DIV : ALU opcodes that the decoder routes to the sequencer
//     - RSTATUS_MUL/DIV: exception codes written to $rstatus
//     - REG_RSTATUS    : register index of $rstatus
//     - rstatus_code() : selects the exception code for a mul or div
// ---------------------------------------------------------------------------
package multdiv_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } state_t;

    localparam logic [4:0] ALU_OP_MUL = 5'b00110;
    localparam logic [4:0] ALU_OP_DIV = 5'b00111;

    localparam int RSTATUS_MUL = 4;
    localparam int RSTATUS_DIV = 5;
    localparam int REG_RSTATUS = 30;

    // Exception code reported in $rstatus for a failed mul or div.
    function automatic logic [3:0] rstatus_code(input logic is_div);
        return is_div ? 4'(RSTATUS_DIV) : 4'(RSTATUS_MUL);
    endfunction

endpackage

// File: rtl/multdiv_sequencer_if.sv
// ---------------------------------------------------------------------------
// multdiv_sequencer_if
//   Bundles the sequencer's pipeline-facing signals:
//     issue_*        : op issued from DX (valid, is_div, operands, rd, ready)
//     flush          : branch/jump squash
//     md_*           : operands, start pulses and result from the multdiv unit
//     stall, busy    : pipeline freeze and occupancy
//     wb_*           : MW regfile write request/grant, register and data
//   Modports:
//     master : the sequencer itself
//     slave  : the surrounding pipeline / multdiv / regfile arbiter
// ---------------------------------------------------------------------------
interface multdiv_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              issue_valid;
    logic              issue_is_div;
    logic [DATA_W-1:0] issue_a;
    logic [DATA_W-1:0] issue_b;
    logic [REG_W-1:0]  issue_rd;
    logic              issue_ready;
    logic              flush;

    logic [DATA_W-1:0] md_op_a;
    logic [DATA_W-1:0] md_op_b;
    logic              md_ctrl_mult;
    logic              md_ctrl_div;
    logic [DATA_W-1:0] md_result;
    logic              md_exception;
    logic              md_result_rdy;

    logic              stall;
    logic              busy;

    logic              wb_req;
    logic              wb_grant;
    logic [REG_W-1:0]  wb_reg;
    logic [DATA_W-1:0] wb_data;

    modport master (
        input  issue_valid, issue_is_div, issue_a, issue_b, issue_rd, flush,
        input  md_result, md_exception, md_result_rdy, wb_grant,
        output issue_ready, md_op_a, md_op_b, md_ctrl_mult, md_ctrl_div,
        output stall, busy, wb_req, wb_reg, wb_data
    );

    modport slave (
        output issue_valid, issue_is_div, issue_a, issue_b, issue_rd, flush,
        output md_result, md_exception, md_result_rdy, wb_grant,
        input  issue_ready, md_op_a, md_op_b, md_ctrl_mult, md_ctrl_div,
        input  stall, busy, wb_req, wb_reg, wb_data
    );

endinterface

// File: rtl/multdiv_sequencer_timeout_counter.sv
// ---------------------------------------------------------------------------
// mdiv_timeout_counter
//   6-bit WAIT-cycle counter with terminal compare. Only built when
//   MULTDIV_TIMEOUT_EN is defined.
//   Ports:
//     clock   in  : clock
//     reset   in  : synchronous active-high reset
//     clear   in  : hold count at zero (asserted whenever not in WAIT)
//     en      in  : count this cycle (asserted in WAIT)
//     expired out : this is the TIMEOUT_CYCLES-th WAIT cycle
// ---------------------------------------------------------------------------
module mdiv_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);
    logic [5:0] count_reg;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + 6'd1;
        end
    end

    // The count holds the number of WAIT cycles already completed, so the
    // cycle that brings it to TIMEOUT_CYCLES is the one where it reads N-1.
    assign expired = en && (count_reg == 6'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multdiv_sequencer.sv
// ---------------------------------------------------------------------------
// multdiv_sequencer
//   Multi-cycle controller for the shared multdiv unit. Captures one mul/div
//   from DX, pulses the multdiv start control for one cycle, stalls the front
//   of the pipeline while the unit works, then requests the MW regfile write
//   port. On a multdiv exception the write is redirected to $rstatus (r30)
//   with code 4 (mul) or 5 (div).
//   Ports:
//     clock : clock, all state on rising edge
//     reset : synchronous active-high reset
//     bus   : multdiv_sequencer_if.master (issue, flush, multdiv, stall, wb)
//   Optional build macro MULTDIV_TIMEOUT_EN: forces an exception writeback
//   after TIMEOUT_CYCLES WAIT cycles without a result.
// ---------------------------------------------------------------------------
module multdiv_sequencer
    import multdiv_sequencer_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int REG_W          = 5,
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic                   clock,
    input  logic                   reset,
    multdiv_sequencer_if.master    bus
);
    state_t            state_reg;
    logic              is_div_reg;
    logic [DATA_W-1:0] op_a_reg;
    logic [DATA_W-1:0] op_b_reg;
    logic [REG_W-1:0]  rd_reg;
    logic              ctrl_mult_reg;
    logic              ctrl_div_reg;
    logic              issue_ready_reg;
    logic              busy_reg;
    logic              wb_req_reg;
    logic [REG_W-1:0]  wb_reg_reg;
    logic [DATA_W-1:0] wb_data_reg;
    logic              timeout_hit;

`ifdef MULTDIV_TIMEOUT_EN
    mdiv_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (state_reg != ST_WAIT),
        .en      (state_reg == ST_WAIT),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
    wire unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            is_div_reg      <= 1'b0;
            op_a_reg        <= '0;
            op_b_reg        <= '0;
            rd_reg          <= '0;
            ctrl_mult_reg   <= 1'b0;
            ctrl_div_reg    <= 1'b0;
            issue_ready_reg <= 1'b1;
            busy_reg        <= 1'b0;
            wb_req_reg      <= 1'b0;
            wb_reg_reg      <= '0;
            wb_data_reg     <= '0;
        end else begin
            // Start controls are single-cycle pulses; only the IDLE->START
            // transition raises them.
            ctrl_mult_reg <= 1'b0;
            ctrl_div_reg  <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    // A result arriving here belongs to a squashed op; ignore.
                    if (bus.issue_valid && !bus.flush) begin
                        is_div_reg      <= bus.issue_is_div;
                        op_a_reg        <= bus.issue_a;
                        op_b_reg        <= bus.issue_b;
                        rd_reg          <= bus.issue_rd;
                        ctrl_mult_reg   <= ~bus.issue_is_div;
                        ctrl_div_reg    <= bus.issue_is_div;
                        issue_ready_reg <= 1'b0;
                        busy_reg        <= 1'b1;
                        state_reg       <= ST_START;
                    end
                end

                ST_START: begin
                    // The unit cannot have finished yet, so rdy is not looked at.
                    if (bus.flush) begin
                        issue_ready_reg <= 1'b1;
                        busy_reg        <= 1'b0;
                        state_reg       <= ST_IDLE;
                    end else begin
                        state_reg <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (bus.flush) begin
                        issue_ready_reg <= 1'b1;
                        busy_reg        <= 1'b0;
                        state_reg       <= ST_IDLE;
                    end else if (bus.md_result_rdy) begin
                        if (bus.md_exception) begin
                            wb_reg_reg  <= REG_W'(REG_RSTATUS);
                            wb_data_reg <= DATA_W'(rstatus_code(is_div_reg));
                        end else begin
                            wb_reg_reg  <= rd_reg;
                            wb_data_reg <= bus.md_result;
                        end
                        wb_req_reg <= 1'b1;
                        state_reg  <= ST_WB;
                    end else if (timeout_hit) begin
                        wb_reg_reg  <= REG_W'(REG_RSTATUS);
                        wb_data_reg <= DATA_W'(rstatus_code(is_div_reg));
                        wb_req_reg  <= 1'b1;
                        state_reg   <= ST_WB;
                    end
                end

                ST_WB: begin
                    // The op is committed here, so flush has no effect.
                    if (bus.wb_grant) begin
                        wb_req_reg      <= 1'b0;
                        issue_ready_reg <= 1'b1;
                        busy_reg        <= 1'b0;
                        state_reg       <= ST_IDLE;
                    end
                end

                default: begin
                    issue_ready_reg <= 1'b1;
                    busy_reg        <= 1'b0;
                    wb_req_reg      <= 1'b0;
                    state_reg       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.issue_ready  = issue_ready_reg;
    assign bus.busy         = busy_reg;
    assign bus.md_op_a      = op_a_reg;
    assign bus.md_op_b      = op_b_reg;
    assign bus.md_ctrl_mult = ctrl_mult_reg;
    assign bus.md_ctrl_div  = ctrl_div_reg;
    assign bus.wb_req       = wb_req_reg;
    assign bus.wb_reg       = wb_reg_reg;
    assign bus.wb_data      = wb_data_reg;

    // The issuing cycle must also stall so the instruction behind the mul/div
    // cannot advance before the sequencer has taken it.
    assign bus.stall = (state_reg != ST_IDLE) ||
                       (bus.issue_valid && (state_reg == ST_IDLE));

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Multi-cycle controller for the shared multdiv unit in the 5-stage pipeline.
- Accepts one mul/div issued from DX and captures its operands and destination.
- Pulses the multdiv start control, then stalls PC/FD/DX until the result is written back.
- Requests a regfile write slot at MW and, on exception, redirects the write to $rstatus with the op's code.

Parameters:
- DATA_W, 32, operand/result width.
- REG_W, 5, register index width.
- TIMEOUT_CYCLES, 40, max WAIT cycles before forced exception (used only with MULTDIV_TIMEOUT_EN).

Ports:
- clock  in  1  master clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- issue_valid  in  1  DX holds a mul or div.
- issue_is_div  in  1  1 = div, 0 = mul; sampled with issue_valid.
- issue_a  in  DATA_W  bypassed operand A.
- issue_b  in  DATA_W  bypassed operand B.
- issue_rd  in  REG_W  destination register.
- issue_ready  out  1  sequencer can accept an issue (IDLE).
- flush  in  1  squash in-flight op (branch/jump redirect).
- md_op_a  out  DATA_W  held operand A to multdiv.
- md_op_b  out  DATA_W  held operand B to multdiv.
- md_ctrl_mult  out  1  one-cycle start pulse, multiply.
- md_ctrl_div  out  1  one-cycle start pulse, divide.
- md_result  in  DATA_W  multdiv result.
- md_exception  in  1  multdiv overflow / divide-by-zero.
- md_result_rdy  in  1  multdiv result valid.
- stall  out  1  freeze PC, FD and DX.
- busy  out  1  state != IDLE.
- wb_req  out  1  request MW regfile write port.
- wb_grant  in  1  write port granted this cycle.
- wb_reg  out  REG_W  writeback register.
- wb_data  out  DATA_W  writeback data.

Behaviour:
- States: IDLE, START, WAIT, WB (2-bit encoding).
- Reset (any state): state = IDLE. All outputs 0 except issue_ready = 1. Operand, rd and result registers cleared.
- IDLE:
  - issue_ready = 1.
  - On issue_valid & ~flush: capture a, b, rd and is_div; go to START.
  - issue_valid & flush: ignored.
  - md_result_rdy in IDLE is ignored (stale result from an aborted op).
- START:
  - Exactly one cycle.
  - md_ctrl_mult = ~is_div, md_ctrl_div = is_div.
  - md_op_a/b valid from this cycle until leaving WAIT.
  - Always go to WAIT; md_result_rdy is ignored this cycle.
  - flush in START: go to IDLE.
- WAIT:
  - On md_result_rdy: capture result into the wb registers; go to WB.
    - md_exception = 0: wb_reg = rd, wb_data = md_result.
    - md_exception = 1: wb_reg = 30, wb_data = 4 (mul) or 5 (div).
  - flush (takes priority over rdy): go to IDLE; no writeback.
- WB:
  - wb_req = 1; wb_reg and wb_data stable.
  - On wb_grant: go to IDLE. Writeback latency = grant cycle.
  - flush is ignored (op already committed).
- rd = 0 with no exception: wb_req is still raised so the stall releases; wb_reg = 0 (regfile discards the write).
- stall = (state != IDLE) | (issue_valid & state == IDLE).
  - Dependent instructions cannot pass the op.
  - stall drops in the cycle after grant.
- Minimum issue-to-writeback: 3 cycles plus multdiv latency.
- No second issue is accepted until back in IDLE.

Optional Feature:
- Macro MULTDIV_TIMEOUT_EN.
- Defined:
  - 6-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When the count reaches TIMEOUT_CYCLES without rdy: go to WB with exception writeback (reg 30, code 4/5).
  - rdy and timeout in the same cycle: rdy wins.
- Undefined: no counter; WAIT holds indefinitely.

Decomposition:
- Shared package holds:
  - state enum constants;
  - ALU_OP_MUL = 5'b00110, ALU_OP_DIV = 5'b00111;
  - RSTATUS_MUL = 4, RSTATUS_DIV = 5;
  - REG_RSTATUS = 30.
- One natural sub-module: mdiv_timeout_counter (counter + compare), instantiated only under MULTDIV_TIMEOUT_EN.
- The FSM stays in the top module.

Test Plan:
- Mul, no exception:
  - Stimulus: issue a = 7, b = 6, rd = 3, mul; rdy after 33 cycles with result 42; grant the same cycle as wb_req.
  - Response: one-cycle md_ctrl_mult; stall high throughout; wb_reg = 3, wb_data = 42; return to IDLE.
- Div by zero:
  - Stimulus: issue a = 10, b = 0, div; exception = 1 at rdy.
  - Response: wb_reg = 30, wb_data = 5; md_ctrl_div pulsed once.
- Flush in WAIT:
  - Stimulus: issue mul, then assert flush 5 cycles later; later stale rdy.
  - Response: IDLE next cycle; no wb_req; stall low; stale rdy ignored.
- Grant delay:
  - Stimulus: hold wb_grant low for 4 cycles in WB.
  - Response: wb_req, wb_reg and wb_data held stable; stall high until the cycle after grant.
- Reset mid-op:
  - Stimulus: reset during WAIT.
  - Response: next edge IDLE; all outputs 0; issue_ready = 1.
- MULTDIV_TIMEOUT_EN with TIMEOUT_CYCLES = 40, no rdy:
  - Stimulus: issue mul; never assert rdy.
  - Response: after 40 WAIT cycles, WB with wb_reg = 30, wb_data = 4.
